seq_divider: RTL
================

# seq_divider

Multicycle signed 32-bit divider that answers the control unit's start/done handshake and implements the `div` instruction. It places the quotient on LO and the remainder on HI. Those outputs feed the high/low registers and the register-file write-back path. The block uses a 32-iteration restoring algorithm on operand magnitudes, then a sign-fix step, and reports a zero divisor without running.

## Interface
- No parameters; width is fixed at 32 bits.
- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low; sampled on the clock edge.
- start  in  1  request pulse from the control unit; sampled only in IDLE.
- A  in  32  dividend, two's complement; captured on the accepting edge.
- B  in  32  divisor, two's complement; captured on the accepting edge.
- HI  out  32  remainder of the last completed division.
- LO  out  32  quotient of the last completed division.
- done  out  1  one-cycle pulse at completion or at divide-by-zero rejection.
- div_zero  out  1  one-cycle pulse, coincident with done, when B==0.
- busy  out  1  high in ITER and FIX.

## Operation
- States:
  - IDLE: waits for start.
  - ITER: 32 shift/subtract steps, 6-bit counter from 0 to 31.
  - FIX: applies the result signs.
- IDLE with start=1 and B!=0:
  - latch |A| and |B| as unsigned 32-bit magnitudes.
  - latch sign_q = A[31]^B[31] and sign_r = A[31].
  - clear the partial remainder and the counter; go to ITER.
- IDLE with start=1 and B==0: stay in IDLE; next cycle done=1 and div_zero=1; HI/LO unchanged.
- ITER, each cycle:
  - rem' = {rem[30:0], dvd[31]}, then dvd shifts left.
  - if rem' >= |B| (33-bit unsigned compare): rem = rem' - |B| and shift in quotient bit 1; otherwise rem = rem' and shift in 0.
  - after counter 31, go to FIX.
- FIX:
  - LO = sign_q ? -q : q; HI = sign_r ? -rem : rem (32-bit two's complement).
  - assert done for one cycle; return to IDLE.
- Semantics: quotient truncates toward zero; remainder takes the dividend's sign; A = LO*B + HI.
- Magnitude of 0x80000000 is 0x80000000 unsigned, with no wrap error.
- 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0; no flag is raised.
- start is ignored while busy=1. A and B may change after the accepting edge without effect.

## Timing
- Reset (reset=0 at an edge): state IDLE; HI=0, LO=0, done=0, div_zero=0, busy=0; counter and datapath registers cleared.
- Reset overrides everything, including mid-ITER: the operation is abandoned with no done pulse.
- Call the edge that samples start in IDLE edge 0. Then:
  - busy=1 from after edge 0 until after edge 33.
  - ITER occupies edges 1..32; FIX occupies edge 33.
  - HI, LO and done=1 are valid in the cycle after edge 33; done drops after edge 34.
  - total latency is 34 clocks from the start edge to the done cycle.
- Zero-divisor rejection: done=div_zero=1 in the cycle after edge 0; busy stays 0.
- In the done cycle the block is already in IDLE: start=1 there is accepted at edge 34 with no bubble.
- HI/LO hold their values until the next non-zero-divisor completion or reset; they do not change during ITER.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- A=100, B=7, start pulse -> done exactly 34 clocks after the start edge; LO=14, HI=2, div_zero=0.
- A=-100 (0xFFFFFF9C), B=7 -> LO=0xFFFFFFF2 (-14), HI=0xFFFFFFFE (-2). Then A=100, B=-7 -> LO=0xFFFFFFF2, HI=2.
- After a 100/7 result, A=5, B=0 -> done=div_zero=1 one cycle after start; busy never rises; HI=2, LO=14 retained.
- A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0, div_zero=0. Also A=3, B=10 -> LO=0, HI=3.
- Start 100/7, pulse start with A=1, B=1 at edge 10 -> ignored; result is still 14/2 at the cycle after edge 33. Back-to-back start in the done cycle with 9/2 -> LO=4, HI=1 34 clocks later.
- Start a division, drive reset=0 at edge 20 -> no done pulse; all outputs are 0 and busy=0 after that edge. A subsequent 100/7 completes normally.

Source files
------------

// File: rtl/seq_divider.sv
// Multicycle signed 32-bit divider: restoring division on operand magnitudes
// followed by a sign-fix step; quotient on LO, remainder on HI.
module seq_divider (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        done,
    output logic        div_zero,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

    state_t      state, state_next;
    logic [31:0] dvd;        // dividend magnitude; quotient bits shift in at the bottom
    logic [31:0] dsr;
    logic [31:0] rem;
    logic [5:0]  cnt;
    logic        sign_q, sign_r;

    logic [31:0] a_mag, b_mag;
    logic [32:0] rem_shift;
    logic        fits;

    // Negating 0x80000000 yields 0x80000000, which is the correct unsigned magnitude.
    assign a_mag     = A[31] ? -A : A;
    assign b_mag     = B[31] ? -B : B;
    assign rem_shift = {rem, dvd[31]};
    assign fits      = rem_shift >= {1'b0, dsr};
    assign busy      = (state != IDLE);

    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: state_next is assigned before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start && (B != 32'd0)) state_next = ITER;
            ITER:    if (cnt == 6'd31)          state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            dvd      <= '0;
            dsr      <= '0;
            rem      <= '0;
            cnt      <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            HI       <= '0;
            LO       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (B == 32'd0) begin
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                        end else begin
                            dvd    <= a_mag;
                            dsr    <= b_mag;
                            sign_q <= A[31] ^ B[31];
                            sign_r <= A[31];
                            rem    <= '0;
                            cnt    <= '0;
                        end
                    end
                end
                ITER: begin
                    // The difference is below dsr when taken, so 32 bits hold it exactly.
                    rem <= fits ? (rem_shift[31:0] - dsr) : rem_shift[31:0];
                    dvd <= {dvd[30:0], fits};
                    cnt <= cnt + 6'd1;
                end
                FIX: begin
                    LO   <= sign_q ? -dvd : dvd;
                    HI   <= sign_r ? -rem : rem;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
